// File: rtl/tc_conv_arb.sv
// tc_conv_arb: two-port round-robin front end sharing one 32-bit adder that
// converts between two's-complement and sign-magnitude in either direction.
module tc_conv_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_dir,
    input  logic [31:0] req_data0,
    input  logic [31:0] req_data1,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_data,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] opnd_q, opnd_d;
    logic        dir_q, dir_d;
    logic        gnt_q, gnt_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [1:0]  rsp_valid_q, rsp_valid_d;

    logic        grant;
    logic        accept;
    logic [30:0] mag;
    logic [30:0] add_op1;
    logic [30:0] add_op2;
    logic [30:0] add_sum;
    logic [31:0] conv_result;

    // Arbitration: single requester wins outright, contention goes to the port
    // that was not served last. Nothing is offered while in reset.
    always_comb begin
        grant  = 1'b0;
        accept = 1'b0;
        if (state_q == IDLE && !rst) begin
            accept = |req_valid;
            if (req_valid == 2'b11) begin
                grant = ~last_grant_q;
            end else begin
                grant = req_valid[1];
            end
        end
        req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
    end

    // Shared adder and result fix-up. Bit 31 of the operands only feeds sum[31],
    // which the result never uses, so the adder is kept to the low 31 bits.
    always_comb begin
        mag     = opnd_q[30:0];
        add_op1 = dir_q ? mag : ~mag;
        add_op2 = dir_q ? '1 : 31'd1;
        add_sum = add_op1 + add_op2;
        if (mag == '0) begin
            conv_result = '0;
        end else if (!opnd_q[31]) begin
            conv_result = opnd_q;
        end else begin
            conv_result = {1'b1, dir_q ? ~add_sum : add_sum};
        end
    end

    // Next-state and datapath register inputs.
    always_comb begin
        state_d      = state_q;
        opnd_d       = opnd_q;
        dir_d        = dir_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        rsp_data_d   = rsp_data_q;
        rsp_valid_d  = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    opnd_d  = grant ? req_data1 : req_data0;
                    dir_d   = req_dir[grant];
                    gnt_d   = grant;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = conv_result;
                rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready[gnt_q]) begin
                    rsp_valid_d  = '0;
                    last_grant_d = gnt_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                rsp_valid_d = '0;
                state_d     = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            opnd_q       <= '0;
            dir_q        <= 1'b0;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_data_q   <= '0;
            rsp_valid_q  <= '0;
        end else begin
            state_q      <= state_d;
            opnd_q       <= opnd_d;
            dir_q        <= dir_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            rsp_data_q   <= rsp_data_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);

endmodule
